fpnew_sdotp_result_packer: RTL and testbench



---
 rtl/fpnew_sdotp_result_packer.sv | 106 ++++++++++
 tb/tb_fpnew_sdotp_result_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_sdotp_result_packer.sv
// Collects narrow sdotp results into lane-width words, NaN-boxing unfilled
// upper slots and merging status/extension flags across each group.
module fpnew_sdotp_result_packer #(
   parameter int unsigned LaneWidth = 64,
   parameter int unsigned ResWidth  = 32,
   parameter int unsigned TagWidth  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [ResWidth-1:0]  result_i,
   input  logic [4:0]           status_i,
   input  logic                 ext_bit_i,
   input  logic                 last_i,
   input  logic [TagWidth-1:0]  tag_i,
   input  logic                 flush_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [LaneWidth-1:0] result_o,
   output logic [4:0]           status_o,
   output logic                 extension_bit_o,
   output logic [TagWidth-1:0]  tag_o,
   output logic                 busy_o
);

   localparam int unsigned NumSlots = LaneWidth / ResWidth;
   localparam int unsigned CntWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
   localparam logic [CntWidth-1:0] LastSlot = CntWidth'(NumSlots - 1);

   logic [LaneWidth-1:0] asm_data;
   logic [CntWidth-1:0]  cnt;
   logic [4:0]           acc_status;
   logic                 acc_ext;
   logic [TagWidth-1:0]  acc_tag;

   logic                 accept;
   logic                 close;
   logic                 first;
   logic [LaneWidth-1:0] pack_word;
   logic [4:0]           pack_status;
   logic                 pack_ext;
   logic [TagWidth-1:0]  pack_tag;

   // Handshake and status are derived from registered state only (plus out_ready_i).
   assign in_ready_o = !out_valid_o || out_ready_i;
   assign busy_o     = (cnt != '0) || out_valid_o;

   assign accept = in_valid_i && in_ready_o && !flush_i;
   assign close  = accept && (last_i || (cnt == LastSlot));
   assign first  = (cnt == '0);

   // Word as it would look if the current beat were written and the group closed here.
   always_comb begin
      pack_word = asm_data;
      for (int unsigned k = 0; k < NumSlots; k++) begin
         if (CntWidth'(k) == cnt) begin
            pack_word[k*ResWidth +: ResWidth] = result_i;
         end else if (CntWidth'(k) > cnt) begin
            pack_word[k*ResWidth +: ResWidth] = '1;
         end
      end
      pack_status = first ? status_i  : (acc_status | status_i);
      pack_ext    = first ? ext_bit_i : (acc_ext & ext_bit_i);
      pack_tag    = first ? tag_i     : acc_tag;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         asm_data        <= '0;
         cnt             <= '0;
         acc_status      <= '0;
         acc_ext         <= 1'b0;
         acc_tag         <= '0;
         out_valid_o     <= 1'b0;
         result_o        <= '0;
         status_o        <= '0;
         extension_bit_o <= 1'b0;
         tag_o           <= '0;
      end else if (flush_i) begin
         cnt         <= '0;
         acc_status  <= '0;
         acc_ext     <= 1'b0;
         out_valid_o <= 1'b0;
      end else begin
         if (accept) begin
            asm_data   <= pack_word;
            acc_status <= pack_status;
            acc_ext    <= pack_ext;
            acc_tag    <= pack_tag;
            cnt        <= close ? '0 : cnt + CntWidth'(1);
         end
         // A close during a drain simply replaces the outgoing word.
         if (close) begin
            out_valid_o     <= 1'b1;
            result_o        <= pack_word;
            status_o        <= pack_status;
            extension_bit_o <= pack_ext;
            tag_o           <= pack_tag;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fpnew_sdotp_result_packer.sv
// Directed bench for fpnew_sdotp_result_packer: 2-slot (64/32) and 4-slot (64/16) instances.
module tb_fpnew_sdotp_result_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   // 64/32 instance
   logic        in_valid, in_ready, ext_bit, last, flush, out_valid, out_ready, ext_o, busy;
   logic [31:0] result;
   logic [4:0]  status, status_o;
   logic [0:0]  tag, tag_o;
   logic [63:0] result_o;
   // 64/16 instance
   logic        in_valid4, in_ready4, ext4, last4, flush4, out_valid4, out_ready4, ext_o4, busy4;
   logic [15:0] result4;
   logic [4:0]  status4, status_o4;
   logic [0:0]  tag4, tag_o4;
   logic [63:0] result_o4;

   int tests = 0;
   int failed = 0;

   fpnew_sdotp_result_packer #(.LaneWidth(64), .ResWidth(32), .TagWidth(1)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .result_i(result), .status_i(status), .ext_bit_i(ext_bit), .last_i(last),
      .tag_i(tag), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .result_o(result_o), .status_o(status_o), .extension_bit_o(ext_o),
      .tag_o(tag_o), .busy_o(busy));

   fpnew_sdotp_result_packer #(.LaneWidth(64), .ResWidth(16), .TagWidth(1)) dut4 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .result_i(result4), .status_i(status4), .ext_bit_i(ext4), .last_i(last4),
      .tag_i(tag4), .flush_i(flush4), .out_valid_o(out_valid4), .out_ready_i(out_ready4),
      .result_o(result_o4), .status_o(status_o4), .extension_bit_o(ext_o4),
      .tag_o(tag_o4), .busy_o(busy4));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  st;
      logic        ext;
      logic        lst;
      logic        tg;
      logic        exp_valid;
      logic [63:0] exp_word;
      logic [4:0]  exp_st;
      logic        exp_ext;
      logic        exp_tag;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [31:0] r, input logic [4:0] s, input logic e,
                       input logic l, input logic t);
      @(negedge clk);
      in_valid = 1'b1; result = r; status = s; ext_bit = e; last = l; tag = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic beat4(input logic [15:0] r, input logic [4:0] s, input logic e,
                        input logic l, input logic t);
      @(negedge clk);
      in_valid4 = 1'b1; result4 = r; status4 = s; ext4 = e; last4 = l; tag4 = t;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] held;

      vecs[0] = '{32'h3F800000, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 5'b00000, 1'b0, 1'b0};
      vecs[1] = '{32'h40000000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 64'h40000000_3F800000, 5'b00001, 1'b1, 1'b1};
      vecs[2] = '{32'h3F800000, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFF_3F800000, 5'b10000, 1'b0, 1'b0};
      vecs[3] = '{32'h11111111, 5'b00100, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 5'b00000, 1'b0, 1'b0};
      vecs[4] = '{32'h22222222, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b1, 64'h22222222_11111111, 5'b00110, 1'b0, 1'b1};

      rst = 1'b1;
      in_valid = 0; result = '0; status = '0; ext_bit = 0; last = 0; tag = '0; flush = 0; out_ready = 1;
      in_valid4 = 0; result4 = '0; status4 = '0; ext4 = 0; last4 = 0; tag4 = '0; flush4 = 0; out_ready4 = 1;

      // Reset state
      #3;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst busy", 64'(busy), 64'd0);
      check("rst result_o", result_o, 64'd0);
      check("rst status_o", 64'(status_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 check("rst in_ready clocked", 64'(in_ready), 64'd1);
      @(negedge clk) rst = 1'b0;

      // Table: full group, early close, status restart, tag from first beat
      for (int i = 0; i < 5; i++) begin
         beat(vecs[i].res, vecs[i].st, vecs[i].ext, vecs[i].lst, vecs[i].tg);
         check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
         check($sformatf("vec%0d busy", i), 64'(busy), 64'd1);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d result_o", i), result_o, vecs[i].exp_word);
            check($sformatf("vec%0d status_o", i), 64'(status_o), 64'(vecs[i].exp_st));
            check($sformatf("vec%0d ext", i), 64'(ext_o), 64'(vecs[i].exp_ext));
            check($sformatf("vec%0d tag", i), 64'(tag_o), 64'(vecs[i].exp_tag));
         end
      end
      @(negedge clk); @(posedge clk); #1;
      check("drain out_valid", 64'(out_valid), 64'd0);
      check("drain busy", 64'(busy), 64'd0);

      // Backpressure: held word stable, stalled beat not taken, replacement with no bubble
      out_ready = 1'b0;
      beat(32'hAAAAAAAA, 5'b00100, 1'b1, 1'b1, 1'b1);
      check("bp held valid", 64'(out_valid), 64'd1);
      held = result_o;
      check("bp held word", held, 64'hFFFFFFFF_AAAAAAAA);
      @(negedge clk);
      in_valid = 1; result = 32'hCCCCCCCC; status = 5'b00010; ext_bit = 1; last = 0; tag = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp stall%0d in_ready", i), 64'(in_ready), 64'd0);
         check($sformatf("bp stall%0d result_o", i), result_o, held);
         check($sformatf("bp stall%0d valid", i), 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1; result = 32'hBBBBBBBB; status = 5'b00001; ext_bit = 0; last = 1; tag = 0;
      #1 check("bp release in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
      check("bp replace valid", 64'(out_valid), 64'd1);
      check("bp replace word", result_o, 64'hFFFFFFFF_BBBBBBBB);
      check("bp replace status", 64'(status_o), 64'(5'b00001));
      check("bp replace tag", 64'(tag_o), 64'd0);
      @(negedge clk); @(posedge clk); #1;
      check("bp final drain", 64'(out_valid), 64'd0);

      // Flush with a partial group, dropping a beat offered in the same cycle
      beat(32'h11223344, 5'b10000, 1'b0, 1'b0, 1'b1);
      check("fl partial busy", 64'(busy), 64'd1);
      @(negedge clk);
      flush = 1; in_valid = 1; result = 32'h55555555; last = 1;
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      check("fl partial valid", 64'(out_valid), 64'd0);
      check("fl partial busy0", 64'(busy), 64'd0);
      // Flush with a held word
      out_ready = 0;
      beat(32'h66666666, 5'b00000, 1'b1, 1'b1, 1'b1);
      check("fl held valid", 64'(out_valid), 64'd1);
      @(negedge clk) flush = 1;
      @(posedge clk); #1 flush = 0;
      check("fl held valid0", 64'(out_valid), 64'd0);
      check("fl held busy0", 64'(busy), 64'd0);
      out_ready = 1;
      beat(32'h77777777, 5'b01000, 1'b1, 1'b0, 1'b0);
      beat(32'h88888888, 5'b00000, 1'b1, 1'b0, 1'b1);
      check("fl next valid", 64'(out_valid), 64'd1);
      check("fl next word", result_o, 64'h88888888_77777777);
      check("fl next status", 64'(status_o), 64'(5'b01000));
      check("fl next tag", 64'(tag_o), 64'd0);
      check("fl next ext", 64'(ext_o), 64'd1);

      // Asynchronous reset with a held word, then with a partial group
      out_ready = 0;
      beat(32'h99999999, 5'b00011, 1'b1, 1'b1, 1'b1);
      check("ar held valid", 64'(out_valid), 64'd1);
      @(negedge clk); #2 rst = 1;
      #1;
      check("ar valid", 64'(out_valid), 64'd0);
      check("ar result_o", result_o, 64'd0);
      check("ar status_o", 64'(status_o), 64'd0);
      check("ar ext", 64'(ext_o), 64'd0);
      check("ar tag", 64'(tag_o), 64'd0);
      check("ar busy", 64'(busy), 64'd0);
      check("ar in_ready", 64'(in_ready), 64'd1);
      @(negedge clk) rst = 0; out_ready = 1;
      beat(32'h12345678, 5'b00001, 1'b1, 1'b0, 1'b1);
      @(negedge clk); #2 rst = 1;
      #1 check("ar partial busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 0;
      beat(32'hABCDEF01, 5'b00000, 1'b1, 1'b1, 1'b0);
      check("ar after valid", 64'(out_valid), 64'd1);
      check("ar after word", result_o, 64'hFFFFFFFF_ABCDEF01);
      check("ar after status", 64'(status_o), 64'd0);
      check("ar after tag", 64'(tag_o), 64'd0);

      // Four-slot instance: early close after 3, then a full group
      beat4(16'h1111, 5'b00001, 1'b1, 1'b0, 1'b1);
      beat4(16'h2222, 5'b00010, 1'b1, 1'b0, 1'b0);
      check("ns4 mid valid", 64'(out_valid4), 64'd0);
      beat4(16'h3333, 5'b00100, 1'b1, 1'b1, 1'b0);
      check("ns4 early valid", 64'(out_valid4), 64'd1);
      check("ns4 early word", result_o4, 64'hFFFF_3333_2222_1111);
      check("ns4 early status", 64'(status_o4), 64'(5'b00111));
      check("ns4 early tag", 64'(tag_o4), 64'd1);
      beat4(16'hAAAA, 5'b00000, 1'b1, 1'b0, 1'b0);
      beat4(16'hBBBB, 5'b00000, 1'b1, 1'b0, 1'b1);
      beat4(16'hCCCC, 5'b10000, 1'b0, 1'b0, 1'b1);
      check("ns4 full pre valid", 64'(out_valid4), 64'd0);
      beat4(16'hDDDD, 5'b00000, 1'b1, 1'b0, 1'b1);
      check("ns4 full valid", 64'(out_valid4), 64'd1);
      check("ns4 full word", result_o4, 64'hDDDD_CCCC_BBBB_AAAA);
      check("ns4 full status", 64'(status_o4), 64'(5'b10000));
      check("ns4 full ext", 64'(ext_o4), 64'd0);
      check("ns4 full tag", 64'(tag_o4), 64'd0);
      @(negedge clk); @(posedge clk); #1;
      check("ns4 busy after drain", 64'(busy4), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
